speles_taimeris: RTL and testbench
==================================

Name: speles_taimeris

Overview:
Countdown timer at the far end of the game logic's timer interface. Consumes the requested round time (time_v) and the timer-start flag (time_f) together with the game state. Counts whole seconds down to zero and returns end_f when the player has run out of time. Also drives the remaining-seconds value as BCD digits for the display and a blinking low-time warning.

Parameters:
TICK_CYCLES, 50000000, clk cycles per one-second tick (must be >= 2); prescaler width = clog2(TICK_CYCLES)
WARN_SECS, 5, warning active while remaining <= WARN_SECS during a run

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
time_f  in  1  timer-start flag from game logic (level; stays high once set)
time_v  in  5  round length in seconds, 0..31
state  in  2  game state: 0 welcome, 1 ready, 2 playing, 3 lost
end_f  out  1  time expired; high while expired in state 2
remaining  out  5  seconds left
secs_tens  out  4  BCD tens of remaining (0..3)
secs_ones  out  4  BCD ones of remaining (0..9)
running  out  1  countdown active
warn  out  1  low-time warning, blinks at tick rate

Behaviour:
- Reset: fsm IDLE, prescaler 0, remaining 0, end_f 0, running 0, warn 0, secs_tens 0, secs_ones 0, sync registers 0.
- Input sync: time_f and state pass through 2-flop synchronizers. Consumers use state_s, which updates only when two consecutive synchronized samples are equal (filters multi-bit skew). time_v is sampled only at arm; the game logic holds it stable while state = 2.
- Arm event: state_s changes from != 2 to == 2 while synced time_f = 1. Evaluated in every fsm state.
- FSM IDLE -> RUN on arm: remaining <= time_v, prescaler <= 0, running <= 1. If time_v = 0: go directly to EXPIRED, end_f <= 1, remaining 0.
- RUN: prescaler increments each cycle. At TICK_CYCLES-1 it wraps to 0 and emits a tick.
  - On tick with remaining > 1: remaining - 1.
  - On tick with remaining = 1: remaining <= 0, end_f <= 1, running <= 0, go to EXPIRED.
- RUN, state_s leaves 2 (answer given): go to IDLE, running <= 0, remaining frozen for display, end_f stays 0.
- EXPIRED: end_f held 1 until state_s leaves 2, then IDLE with end_f <= 0.
- Arm coincident with tick: arm wins and the tick is discarded. A new arm in any state reloads (re-arm).
- Leaving state 2 coincident with the final tick: leave wins and end_f stays 0.
- No wrap-around: remaining never decrements below 0.
- warn = running && remaining <= WARN_SECS && prescaler < TICK_CYCLES/2. Registered, so it lags the prescaler by 1 cycle.
- BCD: secs_tens/secs_ones registered from remaining with 1-cycle latency (tens = remaining/10, ones = remaining%10; remaining <= 31).
- Reset mid-run: everything returns to reset values on the next edge; end_f drops immediately.

Decomposition:
- Shared package holds:
  - Game state constants ST_WELCOME=0, ST_READY=1, ST_PLAY=2, ST_LOST=3 (shared with the game logic).
  - Timer fsm encodings T_IDLE, T_RUN, T_EXPIRED.
  - TIME_W = 5.
- One sub-module, tick_prescaler (params TICK_CYCLES; ports clk, rst, clear, enable, tick, half). It contains the counter, the wrap and the half-period flag used for warn.

Test Plan (TICK_CYCLES=4, WARN_SECS=2):
1. rst, then time_f=1, time_v=3, state 0->1->2 -> running=1 and remaining=3 within 4 cycles. Decrements to 2, 1 at 4-cycle spacing; after the 3rd tick end_f=1, remaining=0, running=0. end_f stays 1 until state=3, then drops.
2. Arm with time_v=10, hold 2 ticks, then state 2->1 -> IDLE, remaining frozen at 8, end_f never 1; secs_tens=0, secs_ones=8.
3. Arm with time_v=0 -> EXPIRED and end_f=1 within 4 cycles of state=2; running never 1.
4. Arm with time_v=31 -> secs_tens=3, secs_ones=1 one cycle after the load. At remaining 2 and 1, warn toggles 1/0 every 2 cycles; at remaining 3, warn = 0.
5. Assert rst mid-run at remaining=5 -> all outputs 0 next cycle. Re-arm with time_v=4 -> counts 4..0 normally.
6. state leaves 2 on the same cycle as the final tick -> IDLE, end_f stays 0. A re-arm coincident with a tick reloads time_v and no decrement is seen.

Source files
------------

// File: rtl/speles_taimeris_pkg.sv
// Shared constants for the game countdown timer: game-state codes,
// timer FSM encodings and the BCD helper used for the display digits.
package speles_taimeris_pkg;

    localparam int TIME_W = 5;

    // Game state codes, identical to the ones the game logic drives
    localparam logic [1:0] ST_WELCOME = 2'd0;
    localparam logic [1:0] ST_READY   = 2'd1;
    localparam logic [1:0] ST_PLAY    = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    localparam logic [1:0] T_IDLE    = 2'd0;
    localparam logic [1:0] T_RUN     = 2'd1;
    localparam logic [1:0] T_EXPIRED = 2'd2;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Remaining time never exceeds 31, so three compares replace a divider
    function automatic bcd_t to_bcd(input logic [TIME_W-1:0] v);
        bcd_t r;
        if (v >= TIME_W'(30)) begin
            r.tens = 4'd3;
            r.ones = 4'(v - TIME_W'(30));
        end else if (v >= TIME_W'(20)) begin
            r.tens = 4'd2;
            r.ones = 4'(v - TIME_W'(20));
        end else if (v >= TIME_W'(10)) begin
            r.tens = 4'd1;
            r.ones = 4'(v - TIME_W'(10));
        end else begin
            r.tens = 4'd0;
            r.ones = 4'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/speles_taimeris_tick_prescaler.sv
// One-second tick generator: counts clk cycles, wraps at TICK_CYCLES-1 and
// reports whether it is in the first half of the second (warning blink phase).
module tick_prescaler #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic half
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] r_count;

    assign tick = enable && (r_count == CW'(TICK_CYCLES - 1));
    assign half = (r_count < CW'(TICK_CYCLES / 2));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/speles_taimeris.sv
// Round countdown timer: arms when the game enters PLAY with the start flag
// set, counts whole seconds down and flags expiry, warning and BCD digits.
module speles_taimeris
    import speles_taimeris_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int WARN_SECS   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              time_f,
    input  logic [TIME_W-1:0] time_v,
    input  logic [1:0]        state,
    output logic              end_f,
    output logic [TIME_W-1:0] remaining,
    output logic [3:0]        secs_tens,
    output logic [3:0]        secs_ones,
    output logic              running,
    output logic              warn
);

    localparam logic [TIME_W-1:0] WARN_V = TIME_W'(WARN_SECS);

    logic              r_tf_s1, r_tf_s2;
    logic [1:0]        r_st_s1, r_st_s2, r_st_s3, r_state_s;
    logic [1:0]        r_fsm;
    logic [TIME_W-1:0] r_remaining;
    logic              r_end_f, r_running, r_warn;
    logic [3:0]        r_tens, r_ones;

    logic [1:0] w_state_next;
    logic       w_arm, w_tick, w_half, w_clear, w_enable;
    bcd_t       w_bcd;

    // A new game state is accepted only once two synchronized samples agree
    assign w_state_next = (r_st_s2 == r_st_s3) ? r_st_s2 : r_state_s;
    assign w_arm        = (w_state_next == ST_PLAY) && (r_state_s != ST_PLAY) && r_tf_s2;
    assign w_enable     = (r_fsm == T_RUN);
    assign w_clear      = w_arm || (r_fsm != T_RUN);
    assign w_bcd        = to_bcd(r_remaining);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tf_s1   <= 1'b0;
            r_tf_s2   <= 1'b0;
            r_st_s1   <= ST_WELCOME;
            r_st_s2   <= ST_WELCOME;
            r_st_s3   <= ST_WELCOME;
            r_state_s <= ST_WELCOME;
        end else begin
            r_tf_s1   <= time_f;
            r_tf_s2   <= r_tf_s1;
            r_st_s1   <= state;
            r_st_s2   <= r_st_s1;
            r_st_s3   <= r_st_s2;
            r_state_s <= w_state_next;
        end
    end

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .enable(w_enable),
        .tick  (w_tick),
        .half  (w_half)
    );

    // Arm has priority over everything; leaving PLAY beats a coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= T_IDLE;
            r_remaining <= '0;
            r_end_f     <= 1'b0;
            r_running   <= 1'b0;
        end else if (w_arm) begin
            if (time_v == '0) begin
                r_fsm       <= T_EXPIRED;
                r_remaining <= '0;
                r_end_f     <= 1'b1;
                r_running   <= 1'b0;
            end else begin
                r_fsm       <= T_RUN;
                r_remaining <= time_v;
                r_end_f     <= 1'b0;
                r_running   <= 1'b1;
            end
        end else begin
            case (r_fsm)
                T_RUN: begin
                    if (w_state_next != ST_PLAY) begin
                        r_fsm     <= T_IDLE;
                        r_running <= 1'b0;
                    end else if (w_tick) begin
                        if (r_remaining > TIME_W'(1)) begin
                            r_remaining <= r_remaining - TIME_W'(1);
                        end else begin
                            r_remaining <= '0;
                            r_end_f     <= 1'b1;
                            r_running   <= 1'b0;
                            r_fsm       <= T_EXPIRED;
                        end
                    end
                end
                T_EXPIRED: begin
                    if (w_state_next != ST_PLAY) begin
                        r_fsm   <= T_IDLE;
                        r_end_f <= 1'b0;
                    end
                end
                T_IDLE: begin
                end
                default: begin
                    r_fsm     <= T_IDLE;
                    r_end_f   <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warn <= 1'b0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else begin
            r_warn <= r_running && (r_remaining <= WARN_V) && w_half;
            r_tens <= w_bcd.tens;
            r_ones <= w_bcd.ones;
        end
    end

    assign end_f     = r_end_f;
    assign remaining = r_remaining;
    assign secs_tens = r_tens;
    assign secs_ones = r_ones;
    assign running   = r_running;
    assign warn      = r_warn;

endmodule

// File: tb/tb_speles_taimeris.sv
// Bench for speles_taimeris: directed scenarios plus random game-state traffic,
// all outputs compared every cycle against a seconds-level behavioural model.
module tb_speles_taimeris;

    localparam int TICK = 4;
    localparam int WARN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       time_f = 1'b0;
    logic [4:0] time_v = 5'd0;
    logic [1:0] state = 2'd0;
    logic       end_f, running, warn;
    logic [4:0] remaining;
    logic [3:0] secs_tens, secs_ones;

    int checkCount = 0;
    int passCount  = 0;

    speles_taimeris #(
        .TICK_CYCLES(TICK),
        .WARN_SECS  (WARN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .time_f   (time_f),
        .time_v   (time_v),
        .state    (state),
        .end_f    (end_f),
        .remaining(remaining),
        .secs_tens(secs_tens),
        .secs_ones(secs_ones),
        .running  (running),
        .warn     (warn)
    );

    always #5 clk = ~clk;

    // Model: game state seen two samples late and accepted once it has been
    // stable for two samples; the round is tracked as seconds left plus the
    // number of cycles elapsed inside the current second.
    int  seen[3];
    int  accepted;
    int  flagSeen[2];
    int  mRem, mPhase, mRunning, mExpired, mEnd, mWarn, mTens, mOnes;
    int  cand, nWarn, nTens, nOnes;
    bit  armEv;
    bit  modelValid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            seen = '{0, 0, 0};
            flagSeen = '{0, 0};
            accepted = 0;
            mRem = 0; mPhase = 0; mRunning = 0; mExpired = 0;
            mEnd = 0; mWarn = 0; mTens = 0; mOnes = 0;
            modelValid = 1'b1;
        end else begin
            nWarn = (mRunning != 0 && mRem <= WARN && mPhase < TICK / 2) ? 1 : 0;
            nTens = mRem / 10;
            nOnes = mRem % 10;
            cand  = (seen[1] == seen[2]) ? seen[1] : accepted;
            armEv = (cand == 2) && (accepted != 2) && (flagSeen[1] != 0);
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = int'(state);
            flagSeen[1] = flagSeen[0];
            flagSeen[0] = int'(time_f);
            accepted = cand;
            if (armEv) begin
                mPhase = 0;
                if (time_v == 0) begin
                    mRem = 0; mRunning = 0; mExpired = 1; mEnd = 1;
                end else begin
                    mRem = int'(time_v); mRunning = 1; mExpired = 0; mEnd = 0;
                end
            end else if (mRunning != 0) begin
                if (cand != 2) begin
                    mRunning = 0;
                end else if (mPhase == TICK - 1) begin
                    mPhase = 0;
                    if (mRem > 1) begin
                        mRem = mRem - 1;
                    end else begin
                        mRem = 0; mRunning = 0; mExpired = 1; mEnd = 1;
                    end
                end else begin
                    mPhase = mPhase + 1;
                end
            end else if (mExpired != 0) begin
                if (cand != 2) begin
                    mExpired = 0; mEnd = 0;
                end
            end
            mWarn = nWarn;
            mTens = nTens;
            mOnes = nOnes;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("end_f",     int'(end_f),     mEnd);
            checkOutput("remaining", int'(remaining), mRem);
            checkOutput("running",   int'(running),   mRunning);
            checkOutput("warn",      int'(warn),      mWarn);
            checkOutput("secs_tens", int'(secs_tens), mTens);
            checkOutput("secs_ones", int'(secs_ones), mOnes);
        end
    end

    // Drive inputs at the current falling edge, then wait n falling edges
    task automatic applyStimulus(input bit r, input bit tf, input int tv, input int st, input int n);
        rst    = r;
        time_f = tf;
        time_v = 5'(tv);
        state  = 2'(st);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitRunning(input int bound);
        for (int i = 0; i < bound && running !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic waitRemaining(input int value, input int bound);
        for (int i = 0; i < bound && remaining !== 5'(value); i++) @(negedge clk);
    endtask

    int  warnPat[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    bit  sawRun;

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset end_f", int'(end_f), 0);
        checkOutput("reset remaining", int'(remaining), 0);
        checkOutput("reset running", int'(running), 0);

        // Scenario 1: 3-second round runs out
        applyStimulus(0, 1, 3, 0, 3);
        applyStimulus(0, 1, 3, 1, 5);
        applyStimulus(0, 1, 3, 2, 0);
        waitRunning(8);
        checkOutput("s1 running", int'(running), 1);
        checkOutput("s1 load", int'(remaining), 3);
        repeat (4) @(negedge clk);
        checkOutput("s1 rem2", int'(remaining), 2);
        repeat (4) @(negedge clk);
        checkOutput("s1 rem1", int'(remaining), 1);
        repeat (4) @(negedge clk);
        checkOutput("s1 rem0", int'(remaining), 0);
        checkOutput("s1 end_f", int'(end_f), 1);
        checkOutput("s1 stop", int'(running), 0);
        applyStimulus(0, 1, 3, 3, 6);
        checkOutput("s1 end drop", int'(end_f), 0);

        // Scenario 2: answer given after two ticks, leave coincides with a tick
        applyStimulus(0, 1, 10, 1, 6);
        applyStimulus(0, 1, 10, 2, 0);
        waitRunning(8);
        waitRemaining(8, 20);
        applyStimulus(0, 1, 10, 1, 8);
        checkOutput("s2 frozen", int'(remaining), 8);
        checkOutput("s2 end_f", int'(end_f), 0);
        checkOutput("s2 tens", int'(secs_tens), 0);
        checkOutput("s2 ones", int'(secs_ones), 8);

        // Scenario 3: zero-length round expires at once
        applyStimulus(0, 1, 0, 2, 0);
        sawRun = 1'b0;
        for (int i = 0; i < 8 && end_f !== 1'b1; i++) begin
            sawRun |= running;
            @(negedge clk);
        end
        checkOutput("s3 end_f", int'(end_f), 1);
        checkOutput("s3 never ran", int'(sawRun), 0);
        applyStimulus(0, 1, 0, 1, 6);

        // Scenario 4: BCD of 31 and the warning blink near the end
        applyStimulus(0, 1, 31, 2, 0);
        waitRunning(8);
        @(negedge clk);
        checkOutput("s4 tens", int'(secs_tens), 3);
        checkOutput("s4 ones", int'(secs_ones), 1);
        waitRemaining(2, 200);
        for (int i = 0; i < 8; i++) begin
            checkOutput("s4 warn blink", int'(warn), warnPat[i]);
            @(negedge clk);
        end
        applyStimulus(0, 1, 31, 1, 6);

        // Scenario 5: reset mid-run, then automatic re-arm with 4
        applyStimulus(0, 1, 7, 2, 0);
        waitRunning(8);
        waitRemaining(5, 40);
        applyStimulus(1, 1, 4, 2, 1);
        checkOutput("s5 rst end_f", int'(end_f), 0);
        checkOutput("s5 rst remaining", int'(remaining), 0);
        checkOutput("s5 rst running", int'(running), 0);
        applyStimulus(0, 1, 4, 2, 0);
        waitRunning(10);
        checkOutput("s5 reload", int'(remaining), 4);
        for (int i = 0; i < 24 && end_f !== 1'b1; i++) @(negedge clk);
        checkOutput("s5 expired", int'(end_f), 1);
        applyStimulus(0, 1, 4, 1, 6);

        // Scenario 6: leave on the final tick, then re-arm
        applyStimulus(0, 1, 1, 2, 0);
        waitRunning(8);
        applyStimulus(0, 1, 1, 1, 6);
        checkOutput("s6 end_f", int'(end_f), 0);
        checkOutput("s6 remaining", int'(remaining), 1);
        applyStimulus(0, 1, 6, 2, 0);
        waitRunning(8);
        repeat (3) @(negedge clk);
        checkOutput("s6 rearm", int'(remaining), 6);
        applyStimulus(0, 1, 6, 1, 6);

        // Random traffic, model-checked every cycle
        for (int k = 0; k < 120; k++) begin
            applyStimulus(($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 7) != 0),
                          $urandom_range(0, 6),
                          (k % 2 == 1) ? 2 : $urandom_range(0, 3),
                          $urandom_range(1, 14));
        end
        applyStimulus(0, 1, 0, 1, 4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
